router_register: RTL and testbench

//  Datapath register stage of the 1x3 router. Sits beside the router FSM

---
 rtl/router_register.sv | 154 +++++++++++++++
 tb/tb_router_register.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_register.sv
// Datapath register stage of the 1x3 router: header latch, FIFO write byte, full-hold replay, parity check.
// Latency: dout, parity_done and low_pkt_valid update one cycle after their strobe; err one cycle after parity_done rises.
// Backpressure: fifo_full parks the arriving byte in full_hold; laf_state replays it. Macro ROUTER_REG_ERR_CNT_EN adds err_cnt.
module router_register #(
   parameter int DATA_WIDTH    = 8,
   parameter int ERR_CNT_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pkt_valid,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  fifo_full,
   input  logic                  detect_add,
   input  logic                  lfd_state,
   input  logic                  ld_state,
   input  logic                  laf_state,
   input  logic                  full_state,
   input  logic                  rst_int_req,
   output logic                  parity_done,
   output logic                  low_pkt_valid,
   output logic                  err,
   output logic [DATA_WIDTH-1:0] dout
`ifdef ROUTER_REG_ERR_CNT_EN
   ,
   output logic [ERR_CNT_WIDTH-1:0] err_cnt
`endif
);

   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic [DATA_WIDTH-1:0] hdr_q, hdr_d;
   logic [DATA_WIDTH-1:0] full_hold_q, full_hold_d;
   logic [DATA_WIDTH-1:0] int_par_q, int_par_d;
   logic [DATA_WIDTH-1:0] pkt_par_q, pkt_par_d;
   logic                  parity_done_q, parity_done_d;
   logic                  parity_done_prev_q, parity_done_prev_d;
   logic                  low_pkt_valid_q, low_pkt_valid_d;
   logic                  err_q, err_d;

   // Next-state for header, write byte, running parity, parity capture and error flag.
   always_comb begin
      hdr_d              = hdr_q;
      dout_d             = dout_q;
      full_hold_d        = full_hold_q;
      int_par_d          = int_par_q;
      pkt_par_d          = pkt_par_q;
      parity_done_d      = parity_done_q;
      parity_done_prev_d = parity_done_q;
      low_pkt_valid_d    = low_pkt_valid_q;
      err_d              = err_q;

      // Destination 2'b11 does not exist, so such a header never replaces the latched one.
      if (detect_add && pkt_valid && (data_in[1:0] != 2'b11)) begin
         hdr_d = data_in;
      end

      if (lfd_state) begin
         dout_d = hdr_q;
      end else if (ld_state && !fifo_full) begin
         dout_d = data_in;
      end else if (ld_state) begin
         // FIFO refused this byte; keep it for replay in LOAD_AFTER_FULL.
         full_hold_d = data_in;
      end else if (laf_state) begin
         dout_d = full_hold_q;
      end

      // Parity byte itself arrives with pkt_valid low, so it never folds into int_par.
      if (detect_add) begin
         int_par_d = '0;
      end else if (lfd_state) begin
         int_par_d = int_par_q ^ hdr_q;
      end else if (ld_state && pkt_valid && !full_state) begin
         int_par_d = int_par_q ^ data_in;
      end

      if (detect_add) begin
         parity_done_d = 1'b0;
      end else if ((ld_state && !pkt_valid && !fifo_full) ||
                   (laf_state && low_pkt_valid_q && !parity_done_q)) begin
         pkt_par_d     = data_in;
         parity_done_d = 1'b1;
      end

      // Set has priority over the CHECK_PARITY_ERROR clear.
      if (ld_state && !pkt_valid) begin
         low_pkt_valid_d = 1'b1;
      end else if (rst_int_req) begin
         low_pkt_valid_d = 1'b0;
      end

      // Compare once, the cycle after parity_done first goes high, when pkt_par is stable.
      if (detect_add) begin
         err_d = 1'b0;
      end else if (parity_done_q && !parity_done_prev_q) begin
         err_d = (int_par_q != pkt_par_q);
      end
   end

   // Register stage with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         dout_q             <= '0;
         hdr_q              <= '0;
         full_hold_q        <= '0;
         int_par_q          <= '0;
         pkt_par_q          <= '0;
         parity_done_q      <= 1'b0;
         parity_done_prev_q <= 1'b0;
         low_pkt_valid_q    <= 1'b0;
         err_q              <= 1'b0;
      end else begin
         dout_q             <= dout_d;
         hdr_q              <= hdr_d;
         full_hold_q        <= full_hold_d;
         int_par_q          <= int_par_d;
         pkt_par_q          <= pkt_par_d;
         parity_done_q      <= parity_done_d;
         parity_done_prev_q <= parity_done_prev_d;
         low_pkt_valid_q    <= low_pkt_valid_d;
         err_q              <= err_d;
      end
   end

   assign dout          = dout_q;
   assign parity_done   = parity_done_q;
   assign low_pkt_valid = low_pkt_valid_q;
   assign err           = err_q;

`ifdef ROUTER_REG_ERR_CNT_EN
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;

   // Count each new parity error (err rising), saturating at all-ones.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (err_d && !err_q && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_WIDTH'(1);
      end
   end

   // Error counter register; only reset clears it.
   always_ff @(posedge clk) begin
      if (!rst) begin
         err_cnt_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign err_cnt = err_cnt_q;
`else
   // No error counter in this build; ERR_CNT_WIDTH stays in the parameter list for a uniform interface.
`endif

endmodule

// File: tb/tb_router_register.sv
`timescale 1ns/1ps
module tb_router_register;

   localparam int DW = 8;
   localparam int CW = 8;

   localparam logic [5:0] S_IDLE = 6'b000000;
   localparam logic [5:0] S_DA   = 6'b100000;
   localparam logic [5:0] S_LFD  = 6'b010000;
   localparam logic [5:0] S_LD   = 6'b001000;
   localparam logic [5:0] S_LAF  = 6'b000100;
   localparam logic [5:0] S_FULL = 6'b000010;
   localparam logic [5:0] S_CHK  = 6'b000001;

   logic          clk = 1'b0;
   logic          rst;
   logic          pkt_valid, fifo_full;
   logic          detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_req;
   logic [DW-1:0] data_in;
   logic          parity_done, low_pkt_valid, err;
   logic [DW-1:0] dout;
`ifdef ROUTER_REG_ERR_CNT_EN
   logic [CW-1:0] err_cnt;
`endif

   always #5 clk = ~clk;

   router_register #(.DATA_WIDTH(DW), .ERR_CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
      .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
      .full_state(full_state), .rst_int_req(rst_int_req), .parity_done(parity_done),
      .low_pkt_valid(low_pkt_valid), .err(err), .dout(dout)
`ifdef ROUTER_REG_ERR_CNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   typedef struct {
      logic pd;
      logic low;
      logic er;
      int   cnt;
   } stat_t;

   logic [7:0] byte_q[$];
   stat_t      stat_q[$];
   int         n_chk = 0;
   int         n_fail = 0;

   // Reference state: latched header and number of bad packets since reset.
   logic [7:0] hdr_m = 8'h00;
   int         cnt_m = 0;

   // Per-cycle tags from the driver, delayed to the edge they describe.
   bit       exp_wr = 1'b0;
   bit [1:0] st_chk = 2'd0;
   bit       wr_seen = 1'b0;
   bit [1:0] chk_seen = 2'd0;
   logic     rst_seen = 1'b0;

   always @(posedge clk) begin
      wr_seen  <= exp_wr;
      chk_seen <= st_chk;
      rst_seen <= rst;
   end

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: compares dout on every write/hold cycle and status flags at tagged points.
   initial begin : monitor
      logic [7:0] last_b;
      stat_t      s;
      last_b = 8'h00;
      forever begin
         @(negedge clk);
         if (!rst_seen) begin
            last_b = 8'h00;
            check("reset_dout", 32'(dout), 32'h0);
            check("reset_parity_done", 32'(parity_done), 32'h0);
            check("reset_low_pkt_valid", 32'(low_pkt_valid), 32'h0);
            check("reset_err", 32'(err), 32'h0);
`ifdef ROUTER_REG_ERR_CNT_EN
            check("reset_err_cnt", 32'(err_cnt), 32'h0);
`endif
         end else begin
            if (wr_seen) begin
               if (byte_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL dout_queue: write with empty expected queue, dout=0x%0h", dout);
               end else begin
                  last_b = byte_q.pop_front();
                  check("dout_write", 32'(dout), 32'(last_b));
               end
            end else begin
               check("dout_hold", 32'(dout), 32'(last_b));
            end
            if (chk_seen != 2'd0) begin
               if (stat_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL stat_queue: status point %0d with empty expected queue", chk_seen);
               end else begin
                  s = stat_q.pop_front();
                  check("parity_done", 32'(parity_done), 32'(s.pd));
                  check("low_pkt_valid", 32'(low_pkt_valid), 32'(s.low));
                  check("err", 32'(err), 32'(s.er));
`ifdef ROUTER_REG_ERR_CNT_EN
                  check("err_cnt", 32'(err_cnt), 32'(s.cnt));
`endif
               end
            end
         end
      end
   end

   // One clock of stimulus; wb is the byte the FIFO should see if this cycle writes.
   task automatic cyc(input logic [5:0] strb, input logic pv, input logic ff, input logic [7:0] d,
                      input bit wr, input logic [7:0] wb, input bit [1:0] chk);
      @(posedge clk);
      #1;
      {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_req} = strb;
      pkt_valid = pv;
      fifo_full = ff;
      data_in   = d;
      exp_wr    = wr;
      st_chk    = chk;
      if (wr) byte_q.push_back(wb);
   endtask

   task automatic push_stat(input logic pd, input logic low, input logic er);
      stat_t s;
      s.pd  = pd;
      s.low = low;
      s.er  = er;
      s.cnt = cnt_m;
      stat_q.push_back(s);
   endtask

   // Full packet walk through the FSM states; full_at indexes payload (n = parity byte), -1 = never full.
   task automatic send_pkt(input logic [7:0] hdr, input logic [7:0] pl[8], input int n,
                           input logic [7:0] par, input int full_at);
      logic [7:0] calc;
      logic [7:0] d;
      logic       pv;
      bit         bad;
      calc = hdr;
      for (int i = 0; i < n; i++) calc = calc ^ pl[i];
      bad = (calc != par);

      push_stat(1'b0, 1'b0, 1'b0);
      cyc(S_DA, 1'b1, 1'b0, hdr, 1'b0, 8'h00, 2'd3);
      if (hdr[1:0] != 2'b11) hdr_m = hdr;
      cyc(S_LFD, 1'b1, 1'b0, pl[0], 1'b1, hdr_m, 2'd0);

      for (int i = 0; i <= n; i++) begin
         pv = (i < n);
         d  = (i < n) ? pl[i] : par;
         if (i == full_at) begin
            cyc(S_LD, pv, 1'b1, d, 1'b0, 8'h00, 2'd0);
            cyc(S_FULL, pv, 1'b0, d, 1'b0, 8'h00, 2'd0);
            if (i == n) push_stat(1'b1, 1'b1, 1'b0);
            cyc(S_LAF, pv, 1'b0, d, 1'b1, d, (i == n) ? 2'd1 : 2'd0);
         end else begin
            if (i == n) push_stat(1'b1, 1'b1, 1'b0);
            cyc(S_LD, pv, 1'b0, d, 1'b1, d, (i == n) ? 2'd1 : 2'd0);
         end
      end

      if (bad && cnt_m < (1 << CW) - 1) cnt_m++;
      push_stat(1'b1, 1'b0, bad);
      cyc(S_CHK, 1'b0, 1'b0, 8'($urandom), 1'b0, 8'h00, 2'd2);
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++)
         cyc(S_IDLE, 1'($urandom), 1'($urandom), 8'($urandom), 1'b0, 8'h00, 2'd0);
   endtask

   initial begin : stim
      logic [7:0] pl[8];
      logic [7:0] hdr, par, calc;
      int         n, fa;

      rst = 1'b0;
      {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_req} = 6'($urandom);
      pkt_valid = 1'($urandom);
      fifo_full = 1'($urandom);
      data_in   = 8'($urandom);
      @(posedge clk);
      #1;
      {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_req} = 6'($urandom);
      pkt_valid = 1'($urandom);
      data_in   = 8'($urandom);
      @(posedge clk);
      #1;
      rst = 1'b1;
      {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_req} = S_IDLE;
      pkt_valid = 1'b0;
      fifo_full = 1'b0;
      idle(2);

      pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
      for (int i = 3; i < 8; i++) pl[i] = 8'h00;
      send_pkt(8'h0D, pl, 3, 8'h0D, -1);   // good packet
      idle(1);
      send_pkt(8'h0D, pl, 3, 8'h0C, -1);   // bad parity
      idle(2);
      send_pkt(8'h0D, pl, 3, 8'h0D, 1);    // full while 0x22 arrives
      send_pkt(8'h0D, pl, 3, 8'h0D, 3);    // full on the parity byte

      // Address 2'b11 header: latched header must stay 0x0D.
      cyc(S_DA, 1'b1, 1'b0, 8'h0F, 1'b0, 8'h00, 2'd0);
      cyc(S_LFD, 1'b1, 1'b0, 8'h55, 1'b1, hdr_m, 2'd0);
      idle(2);

      // Three bad packets then a good one.
      send_pkt(8'h0D, pl, 3, 8'hA0, -1);
      send_pkt(8'h0D, pl, 3, 8'h01, 2);
      send_pkt(8'h0D, pl, 3, 8'h0C, 3);
      send_pkt(8'h0D, pl, 3, 8'h0D, -1);
      idle(1);

      for (int p = 0; p < 200; p++) begin
         n   = $urandom_range(1, 6);
         hdr = {6'($urandom), 2'($urandom_range(0, 2))};
         for (int i = 0; i < 8; i++) pl[i] = 8'($urandom);
         calc = hdr;
         for (int i = 0; i < n; i++) calc = calc ^ pl[i];
         par = ($urandom_range(0, 2) == 0) ? (calc ^ 8'($urandom_range(1, 255))) : calc;
         fa  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n) : -1;
         send_pkt(hdr, pl, n, par, fa);
         idle($urandom_range(0, 2));
      end

      idle(4);
      check("bytes_drained", 32'(byte_q.size()), 32'h0);
      check("status_drained", 32'(stat_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
